// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and defaults for the filter datapath run-control block.
//   seq_state_t : run-control FSM states
//   fwd_sel_t   : ALU source forwarding select encoding
//   *_DEFAULT   : parameter defaults used by the sequencer and its interface
package filter_gpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } seq_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

    localparam logic [31:0] HALT_WORD_DEFAULT    = 32'hFFFF_FFFF;
    localparam int          DRAIN_CYCLES_DEFAULT = 4;
    localparam int          CLEAR_CYCLES_DEFAULT = 2;
    localparam int          CNT_W_DEFAULT        = 32;

    // Forwarding source for one execute-stage operand. The memory stage holds
    // the younger result, so it wins over writeback when both match.
    function automatic fwd_sel_t fwd_select(
        input logic [3:0] ra_e,
        input logic [3:0] wa_m,
        input logic [3:0] wa_w,
        input logic       reg_write_m,
        input logic       reg_write_w
    );
        if (reg_write_m && (ra_e == wa_m)) return FWD_MEM;
        if (reg_write_w && (ra_e == wa_w)) return FWD_WB;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Bus between the filter datapath and its run-control sequencer.
//   master : datapath/host side (drives start, fetch word, register ids)
//   slave  : sequencer side (drives reset, enables, clears, forwards, status)
// CNT_W must match the CNT_W of the attached sequencer.
interface pipeline_sequencer_if
    import filter_gpu_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) ();

    logic             start;
    logic [31:0]      InstrF;
    logic [3:0]       ra1D;
    logic [3:0]       ra2D;
    logic [3:0]       ra1E;
    logic [3:0]       ra2E;
    logic [3:0]       WA3E;
    logic [3:0]       WA3M;
    logic [3:0]       WA3W;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             MemtoRegE;

    logic             dp_rst;
    logic             EN1;
    logic             EN2;
    logic             CLR1;
    logic             CLR2;
    fwd_sel_t         ForwardAE;
    fwd_sel_t         ForwardBE;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cycles;
    logic [CNT_W-1:0] stalls;

    modport master (
        output start, InstrF, ra1D, ra2D, ra1E, ra2E, WA3E, WA3M, WA3W,
               RegWriteM, RegWriteW, MemtoRegE,
        input  dp_rst, EN1, EN2, CLR1, CLR2, ForwardAE, ForwardBE,
               busy, done, cycles, stalls
    );

    modport slave (
        input  start, InstrF, ra1D, ra2D, ra1E, ra2E, WA3E, WA3M, WA3W,
               RegWriteM, RegWriteW, MemtoRegE,
        output dp_rst, EN1, EN2, CLR1, CLR2, ForwardAE, ForwardBE,
               busy, done, cycles, stalls
    );

endinterface

// File: rtl/pipeline_sequencer_hazard.sv
// hazard_unit: combinational load-use stall detection and operand forwarding.
//   i_ra1_d/i_ra2_d : decode-stage source registers
//   i_ra1_e/i_ra2_e : execute-stage source registers
//   i_wa3_e/m/w     : destination registers in execute/memory/writeback
//   i_reg_write_m/w : memory/writeback stage writes a register
//   i_mem_to_reg_e  : execute-stage instruction is a load
//   o_stall         : load-use hazard this cycle
//   o_fwd_a/o_fwd_b : SrcA/SrcB forwarding selects
module hazard_unit
    import filter_gpu_pkg::*;
(
    input  logic [3:0] i_ra1_d,
    input  logic [3:0] i_ra2_d,
    input  logic [3:0] i_ra1_e,
    input  logic [3:0] i_ra2_e,
    input  logic [3:0] i_wa3_e,
    input  logic [3:0] i_wa3_m,
    input  logic [3:0] i_wa3_w,
    input  logic       i_reg_write_m,
    input  logic       i_reg_write_w,
    input  logic       i_mem_to_reg_e,
    output logic       o_stall,
    output fwd_sel_t   o_fwd_a,
    output fwd_sel_t   o_fwd_b
);

    // A load result is not available until after memory, so any decode-stage
    // reader of the load's destination must wait one cycle. Register 0 is not
    // exempt.
    assign o_stall = i_mem_to_reg_e && ((i_ra1_d == i_wa3_e) || (i_ra2_d == i_wa3_e));

    assign o_fwd_a = fwd_select(i_ra1_e, i_wa3_m, i_wa3_w, i_reg_write_m, i_reg_write_w);
    assign o_fwd_b = fwd_select(i_ra2_e, i_wa3_m, i_wa3_w, i_reg_write_m, i_reg_write_w);

endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: run-control and hazard controller for the 5-stage
// filter datapath. Starts a run by holding the datapath in reset, runs until
// the halt word is fetched, drains in-flight instructions, then reports the
// run length and the number of load-use stall cycles.
//   CLK : clock
//   RST : synchronous active-high reset
//   bus : slave side of pipeline_sequencer_if (start, fetch word, register
//         ids in; dp_rst, EN1/EN2, CLR1/CLR2, ForwardAE/BE, busy, done,
//         cycles, stalls out)
module pipeline_sequencer
    import filter_gpu_pkg::*;
#(
    parameter logic [31:0] HALT_WORD    = HALT_WORD_DEFAULT,
    parameter int          DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
    parameter int          CLEAR_CYCLES = CLEAR_CYCLES_DEFAULT,
    parameter int          CNT_W        = CNT_W_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST,
    pipeline_sequencer_if.slave  bus
);

    localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

    seq_state_t       r_state;
    logic [CLR_W-1:0] r_clr_cnt;
    logic [DRN_W-1:0] r_drain_cnt;
    logic [CNT_W-1:0] r_cycles;
    logic [CNT_W-1:0] r_stalls;
    logic             r_busy;
    logic             r_done;

    logic             w_stall;
    fwd_sel_t         w_fwd_a;
    fwd_sel_t         w_fwd_b;
    logic             w_halt;
    logic             w_en1;
    logic             w_en2;
    logic             w_clr1;
    logic             w_clr2;

    hazard_unit u_hazard (
        .i_ra1_d        (bus.ra1D),
        .i_ra2_d        (bus.ra2D),
        .i_ra1_e        (bus.ra1E),
        .i_ra2_e        (bus.ra2E),
        .i_wa3_e        (bus.WA3E),
        .i_wa3_m        (bus.WA3M),
        .i_wa3_w        (bus.WA3W),
        .i_reg_write_m  (bus.RegWriteM),
        .i_reg_write_w  (bus.RegWriteW),
        .i_mem_to_reg_e (bus.MemtoRegE),
        .o_stall        (w_stall),
        .o_fwd_a        (w_fwd_a),
        .o_fwd_b        (w_fwd_b)
    );

    assign w_halt = (bus.InstrF == HALT_WORD);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge CLK) begin
        // NOTE: every register here uses <= so all flops update from the same
        // pre-edge values; a blocking = would let later lines see new values.
        if (RST) begin
            // NOTE: the reset is synchronous, so it lives inside the clocked
            // block; it has no sensitivity-list entry of its own.
            r_state     <= IDLE;
            r_clr_cnt   <= '0;
            r_drain_cnt <= '0;
            r_cycles    <= '0;
            r_stalls    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_state   <= CLEAR;
                        r_clr_cnt <= CLR_W'(CLEAR_CYCLES - 1);
                        r_cycles  <= '0;
                        r_stalls  <= '0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (r_clr_cnt == '0) r_state   <= RUN;
                    else                 r_clr_cnt <= r_clr_cnt - CLR_W'(1);
                end
                RUN: begin
                    r_cycles <= sat_inc(r_cycles);
                    if (w_stall) r_stalls <= sat_inc(r_stalls);
                    // A stalled halt is not consumed: the PC is frozen and
                    // the same word is presented again next cycle.
                    if (w_halt && !w_stall) begin
                        r_state     <= DRAIN;
                        r_drain_cnt <= DRN_W'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    r_cycles <= sat_inc(r_cycles);
                    if (w_stall) r_stalls <= sat_inc(r_stalls);
                    // Only non-stalled cycles advance the tail of the pipe.
                    if (!w_stall) begin
                        if (r_drain_cnt == '0) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_drain_cnt <= r_drain_cnt - DRN_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missing
        // branch would otherwise infer a latch.
        w_en1  = 1'b0;
        w_en2  = 1'b0;
        w_clr1 = 1'b1;
        w_clr2 = 1'b1;
        case (r_state)
            RUN: begin
                w_en1  = !w_stall;
                w_en2  = !w_stall;
                w_clr1 = 1'b0;
                w_clr2 = w_stall;
            end
            DRAIN: begin
                // Fetch stays frozen; decode keeps shifting bubbles forward.
                w_en1  = 1'b0;
                w_en2  = !w_stall;
                w_clr1 = !w_stall;
                w_clr2 = w_stall;
            end
            default: ;
        endcase
    end

    assign bus.dp_rst    = RST || (r_state == CLEAR);
    assign bus.EN1       = w_en1;
    assign bus.EN2       = w_en2;
    assign bus.CLR1      = w_clr1;
    assign bus.CLR2      = w_clr2;
    assign bus.ForwardAE = w_fwd_a;
    assign bus.ForwardBE = w_fwd_b;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.cycles    = r_cycles;
    assign bus.stalls    = r_stalls;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer. The driver applies one input set
// per cycle, just after the rising edge, and pushes the expected outputs for
// that cycle from a run-level reference model. A monitor compares every
// cycle on the falling edge and checks each run's totals when done rises.
module tb_pipeline_sequencer;
    import filter_gpu_pkg::*;

    localparam logic [31:0] HALT      = 32'hFFFF_FFFF;
    localparam int          N_DRAIN   = 4;
    localparam int          N_CLEAR   = 2;
    localparam longint      CNT_MAX   = 64'h0000_0000_FFFF_FFFF;

    typedef struct packed {
        logic        dp_rst;
        logic        en1;
        logic        en2;
        logic        clr1;
        logic        clr2;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        busy;
        logic        done;
        logic [31:0] cyc;
        logic [31:0] st;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        start;
        logic [31:0] instr;
        logic [3:0]  ra1_d, ra2_d, ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
        logic        rw_m, rw_w, m2r_e;
    } stim_t;

    logic CLK;
    logic RST;

    pipeline_sequencer_if #(.CNT_W(32)) bus ();

    pipeline_sequencer dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_errors = 0;

    exp_t        exp_q[$];
    logic [63:0] run_q[$];
    stim_t       s;

    // Reference model: where the run is, expressed as remaining work.
    int     m_clear_left = 0;
    bit     m_running    = 0;
    int     m_drain_left = 0;
    bit     m_done       = 0;
    longint m_cyc        = 0;
    longint m_st         = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [3:0] ra, input logic [3:0] wam,
                                           input logic [3:0] waw, input logic rwm, input logic rww);
        if (rwm && ra == wam) return 2'b10;
        if (rww && ra == waw) return 2'b01;
        return 2'b00;
    endfunction

    function automatic longint sat(input longint v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic quiet();
        s.rst = 1'b0;   s.start = 1'b0; s.instr = 32'h0;
        s.ra1_d = 4'd0; s.ra2_d = 4'd0; s.ra1_e = 4'd0; s.ra2_e = 4'd0;
        s.wa3_e = 4'd0; s.wa3_m = 4'd0; s.wa3_w = 4'd0;
        s.rw_m = 1'b0;  s.rw_w = 1'b0;  s.m2r_e = 1'b0;
    endtask

    // One clock cycle: drive s, predict this cycle's outputs, step the model.
    task automatic apply();
        exp_t e;
        bit   stall;
        @(posedge CLK);
        #1;
        RST           = s.rst;
        bus.start     = s.start;
        bus.InstrF    = s.instr;
        bus.ra1D      = s.ra1_d;
        bus.ra2D      = s.ra2_d;
        bus.ra1E      = s.ra1_e;
        bus.ra2E      = s.ra2_e;
        bus.WA3E      = s.wa3_e;
        bus.WA3M      = s.wa3_m;
        bus.WA3W      = s.wa3_w;
        bus.RegWriteM = s.rw_m;
        bus.RegWriteW = s.rw_w;
        bus.MemtoRegE = s.m2r_e;

        stall = s.m2r_e && (s.ra1_d == s.wa3_e || s.ra2_d == s.wa3_e);
        e      = '0;
        e.fa   = fwd_ref(s.ra1_e, s.wa3_m, s.wa3_w, s.rw_m, s.rw_w);
        e.fb   = fwd_ref(s.ra2_e, s.wa3_m, s.wa3_w, s.rw_m, s.rw_w);
        e.cyc  = m_cyc[31:0];
        e.st   = m_st[31:0];
        if (m_clear_left > 0) begin
            e.en1 = 0; e.en2 = 0; e.clr1 = 1; e.clr2 = 1; e.busy = 1;
        end else if (m_running) begin
            e.en1 = !stall; e.en2 = !stall; e.clr1 = 0; e.clr2 = stall; e.busy = 1;
        end else if (m_drain_left > 0) begin
            e.en1 = 0; e.en2 = !stall; e.clr1 = !stall; e.clr2 = stall; e.busy = 1;
        end else begin
            e.en1 = 0; e.en2 = 0; e.clr1 = 1; e.clr2 = 1; e.busy = 0; e.done = m_done;
        end
        e.dp_rst = s.rst || (m_clear_left > 0);
        exp_q.push_back(e);

        if (s.rst) begin
            m_clear_left = 0; m_running = 0; m_drain_left = 0; m_done = 0;
            m_cyc = 0; m_st = 0;
        end else if (m_clear_left > 0) begin
            m_clear_left--;
            if (m_clear_left == 0) m_running = 1;
        end else if (m_running || m_drain_left > 0) begin
            m_cyc = sat(m_cyc + 1);
            if (stall) m_st = sat(m_st + 1);
            if (m_running) begin
                if (s.instr == HALT && !stall) begin
                    m_running    = 0;
                    m_drain_left = N_DRAIN;
                end
            end else if (!stall) begin
                m_drain_left--;
                if (m_drain_left == 0) begin
                    m_done = 1;
                    run_q.push_back({m_cyc[31:0], m_st[31:0]});
                end
            end
        end else if (s.start) begin
            m_clear_left = N_CLEAR;
            m_done = 0; m_cyc = 0; m_st = 0;
        end
    endtask

    // Monitor: decoupled from the driver, compares on the falling edge.
    initial begin
        exp_t        e;
        logic [63:0] r;
        logic        prev_done = 1'b0;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ctrl {dp_rst,EN1,EN2,CLR1,CLR2,FwdA,FwdB,busy,done}",
                      64'({bus.dp_rst, bus.EN1, bus.EN2, bus.CLR1, bus.CLR2,
                           bus.ForwardAE, bus.ForwardBE, bus.busy, bus.done}),
                      64'({e.dp_rst, e.en1, e.en2, e.clr1, e.clr2,
                           e.fa, e.fb, e.busy, e.done}));
                check("counters {cycles,stalls}", {bus.cycles, bus.stalls}, {e.cyc, e.st});
            end
            if (bus.done === 1'b1 && prev_done !== 1'b1) begin
                if (run_q.size() > 0) begin
                    r = run_q.pop_front();
                    check("run_totals {cycles,stalls}", {bus.cycles, bus.stalls}, r);
                end else begin
                    check("done_unexpected", 64'(bus.done), 64'(0));
                end
            end
            prev_done = bus.done;
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST           = 1'b1;
        bus.start     = 1'b0;
        bus.InstrF    = 32'h0;
        bus.ra1D      = 4'd0; bus.ra2D = 4'd0; bus.ra1E = 4'd0; bus.ra2E = 4'd0;
        bus.WA3E      = 4'd0; bus.WA3M = 4'd0; bus.WA3W = 4'd0;
        bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0; bus.MemtoRegE = 1'b0;

        // Reset, then start: two dp_rst cycles, then RUN.
        quiet(); s.rst = 1; apply();
        @(negedge CLK);
        check("reset_status {busy,done,EN1,EN2,CLR1,CLR2,dp_rst}",
              64'({bus.busy, bus.done, bus.EN1, bus.EN2, bus.CLR1, bus.CLR2, bus.dp_rst}),
              64'(7'b0000111));
        check("reset_counters", {bus.cycles, bus.stalls}, 64'd0);
        quiet(); s.start = 1; apply();
        quiet(); apply();
        @(negedge CLK); check("clear_dp_rst_1", 64'(bus.dp_rst), 64'(1));
        apply();
        @(negedge CLK); check("clear_dp_rst_2", 64'(bus.dp_rst), 64'(1));
        apply();
        @(negedge CLK);
        check("run_entry {EN1,EN2,CLR1,CLR2,busy,dp_rst}",
              64'({bus.EN1, bus.EN2, bus.CLR1, bus.CLR2, bus.busy, bus.dp_rst}),
              64'(6'b110010));

        // Load-use stall.
        quiet(); s.m2r_e = 1; s.wa3_e = 4'd3; s.ra1_d = 4'd3; apply();
        @(negedge CLK);
        check("stall_ctrl {EN1,EN2,CLR2}", 64'({bus.EN1, bus.EN2, bus.CLR2}), 64'(3'b001));
        quiet(); apply();
        @(negedge CLK); check("stall_count", 64'(bus.stalls), 64'd1);

        // Forwarding priority, then writeback only.
        quiet(); s.rw_m = 1; s.wa3_m = 4'd5; s.rw_w = 1; s.wa3_w = 4'd5; s.ra1_e = 4'd5; apply();
        @(negedge CLK); check("fwd_a_mem", 64'(bus.ForwardAE), 64'(2'b10));
        s.rw_m = 0; apply();
        @(negedge CLK); check("fwd_a_wb", 64'(bus.ForwardAE), 64'(2'b01));

        // start while busy is ignored.
        quiet(); s.start = 1; apply();
        quiet(); apply();
        @(negedge CLK);
        check("start_ignored {busy,CLR1,dp_rst}", 64'({bus.busy, bus.CLR1, bus.dp_rst}), 64'(3'b100));

        // Halt fetched during a stall: stall wins until the stall clears.
        quiet(); s.instr = HALT; s.m2r_e = 1; s.wa3_e = 4'd7; s.ra2_d = 4'd7; apply(); apply();
        s.m2r_e = 0; apply();
        @(negedge CLK); check("halt_after_stall_still_run {EN1,CLR1}", 64'({bus.EN1, bus.CLR1}), 64'(2'b10));
        quiet(); apply();
        @(negedge CLK); check("drain_ctrl {EN1,CLR1}", 64'({bus.EN1, bus.CLR1}), 64'(2'b01));
        s.m2r_e = 1; s.wa3_e = 4'd9; s.ra1_d = 4'd9; apply();
        quiet(); apply(); apply(); apply();
        apply();
        @(negedge CLK); check("done_status {done,busy}", 64'({bus.done, bus.busy}), 64'(2'b10));

        // Ten clean RUN cycles with halt on the tenth, four DRAIN cycles.
        quiet(); s.start = 1; apply();
        quiet(); apply(); apply();
        repeat (9) apply();
        s.instr = HALT; apply();
        quiet(); repeat (N_DRAIN) apply();
        apply();
        @(negedge CLK);
        check("run14_cycles", 64'(bus.cycles), 64'd14);
        check("run14_stalls", 64'(bus.stalls), 64'd0);
        check("run14_status {done,busy}", 64'({bus.done, bus.busy}), 64'(2'b10));

        // Reset in the middle of DRAIN.
        quiet(); s.start = 1; apply();
        quiet(); apply(); apply();
        repeat (3) apply();
        s.instr = HALT; apply();
        quiet(); apply();
        s.rst = 1; apply();
        quiet(); apply();
        @(negedge CLK);
        check("mid_drain_rst {done,busy}", 64'({bus.done, bus.busy}), 64'(2'b00));
        check("mid_drain_rst_counters", {bus.cycles, bus.stalls}, 64'd0);

        // Randomized traffic: runs, stalls, stray starts and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            s.rst   = ($urandom_range(0, 199) == 0);
            s.start = ($urandom_range(0, 9) == 0);
            s.instr = ($urandom_range(0, 7) == 0) ? HALT : 32'($urandom);
            s.ra1_d = 4'($urandom_range(0, 7));
            s.ra2_d = 4'($urandom_range(0, 7));
            s.ra1_e = 4'($urandom_range(0, 7));
            s.ra2_e = 4'($urandom_range(0, 7));
            s.wa3_e = 4'($urandom_range(0, 7));
            s.wa3_m = 4'($urandom_range(0, 7));
            s.wa3_w = 4'($urandom_range(0, 7));
            s.rw_m  = 1'($urandom_range(0, 1));
            s.rw_w  = 1'($urandom_range(0, 1));
            s.m2r_e = ($urandom_range(0, 2) == 0);
            apply();
        end
        quiet(); apply();
        repeat (2) @(negedge CLK);
        check("runs_all_reported", 64'(run_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
